// File: rtl/dec_n_to_m_seq_if.sv
// Control/output bundle for the sequenced N-to-2^N one-hot decoder.
// The master drives the controls and the slave (the decoder) drives the outputs.
interface dec_n_to_m_seq_if #(
   parameter int N       = 2,
   parameter int DWELL_W = 8
);
   logic               e;
   logic               mode;
   logic [N-1:0]       sel;
   logic               load;
   logic [DWELL_W-1:0] dwell;
   logic [2**N-1:0]    d;
   logic [N-1:0]       idx;
   logic               wrap;

   modport master (output e, mode, sel, load, dwell, input d, idx, wrap);
   modport slave  (input e, mode, sel, load, dwell, output d, idx, wrap);
endinterface

// File: rtl/dec_n_to_m_seq.sv
// Registered one-hot decoder that either decodes sel directly or scans all
// lines, holding each one for dwell+1 cycles.
module dec_n_to_m_seq #(
   parameter int N       = 2,
   parameter int DWELL_W = 8
) (
   input logic              clk,
   input logic              rst_n,
   dec_n_to_m_seq_if.slave  bus
);
   localparam int M = 2**N;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DIRECT = 2'd1;
   localparam logic [1:0] ST_SCAN   = 2'd2;

   logic [1:0]         st;
   logic [M-1:0]       d_q,    d_d;
   logic [N-1:0]       idx_q,  idx_d;
   logic [DWELL_W-1:0] cnt_q,  cnt_d;
   logic               wrap_q, wrap_d;

   // Operating state is purely a function of the sampled inputs.
   always_comb begin
      st = ST_IDLE;
      if (bus.e) st = bus.mode ? ST_SCAN : ST_DIRECT;
   end

   always_comb begin
      idx_d  = idx_q;
      cnt_d  = '0;
      wrap_d = 1'b0;
      d_d    = '0;
      case (st)
         ST_DIRECT: idx_d = bus.sel;
         ST_SCAN: begin
            if (bus.load) begin
               idx_d = bus.sel;
            end else if (cnt_q >= bus.dwell) begin
               // >= so a lowered dwell advances right away instead of overflowing
               idx_d  = idx_q + N'(1);
               wrap_d = &idx_q;
            end else begin
               cnt_d = cnt_q + DWELL_W'(1);
            end
         end
         default: ;
      endcase
      if (st != ST_IDLE) d_d[idx_d] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_q    <= '0;
         idx_q  <= '0;
         cnt_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         d_q    <= d_d;
         idx_q  <= idx_d;
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
      end
   end

   assign bus.d    = d_q;
   assign bus.idx  = idx_q;
   assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_dec_n_to_m_seq.sv
// Scoreboard bench for dec_n_to_m_seq at N=2 and N=3.
module tb_dec_n_to_m_seq;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dec_n_to_m_seq_if #(.N(2), .DWELL_W(8)) bus  ();
   dec_n_to_m_seq_if #(.N(3), .DWELL_W(8)) bus3 ();

   dec_n_to_m_seq #(.N(2), .DWELL_W(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
   dec_n_to_m_seq #(.N(3), .DWELL_W(8)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

   typedef struct packed {
      logic [3:0] d;
      logic [1:0] idx;
      logic       wrap;
   } exp_t;

   typedef struct packed {
      logic [7:0] d;
      logic [2:0] idx;
      logic       wrap;
   } exp3_t;

   exp_t  sb[$];
   exp3_t sb3[$];
   int    pass_cnt = 0;
   int    total    = 0;
   int    m_idx    = 0;
   int    m_cnt    = 0;

   // Drive one cycle of N=2 stimulus, predict the result and advance past the edge.
   task automatic step(input logic e, input logic mode, input logic load,
                       input logic [1:0] sel, input logic [7:0] dwell);
      int   nidx = m_idx;
      int   ncnt = 0;
      logic w    = 1'b0;
      logic [3:0] nd;
      bus.e = e; bus.mode = mode; bus.load = load; bus.sel = sel; bus.dwell = dwell;
      if (e && !mode) nidx = sel;
      else if (e && mode) begin
         if (load) nidx = sel;
         else if (m_cnt >= int'(dwell)) begin
            nidx = (m_idx + 1) % 4;
            w    = (m_idx == 3);
         end else ncnt = m_cnt + 1;
      end
      nd = 4'b0;
      if (e) nd[nidx] = 1'b1;
      sb.push_back('{nd, 2'(nidx), w});
      m_idx = nidx;
      m_cnt = ncnt;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.e = 1'b0; bus.mode = 1'b0; bus.load = 1'b0; bus.sel = '0; bus.dwell = '0;
      bus3.e = 1'b0; bus3.mode = 1'b0; bus3.load = 1'b0; bus3.sel = '0; bus3.dwell = '0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({bus.d, bus.idx, bus.wrap} !== 7'b0) begin
         $display("FAIL reset_state: got d=%b idx=%0d wrap=%b want 0/0/0", bus.d, bus.idx, bus.wrap);
      end else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      m_idx = 0; m_cnt = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_direct();
      exp_t ex;
      for (int s = 0; s < 4; s++) begin
         step(1'b1, 1'b0, 1'b0, 2'(s), 8'd0);
         ex = sb.pop_front();
         total++;
         if ({bus.d, bus.idx, bus.wrap} !== ex || bus.d !== (4'b1 << s)) begin
            $display("FAIL direct_sel%0d: got d=%b idx=%0d wrap=%b want d=%b idx=%0d wrap=%b",
                     s, bus.d, bus.idx, bus.wrap, ex.d, ex.idx, ex.wrap);
         end else pass_cnt++;
      end
      step(1'b0, 1'b0, 1'b0, 2'd1, 8'd0);
      ex = sb.pop_front();
      total++;
      if ({bus.d, bus.idx, bus.wrap} !== ex || bus.d !== 4'b0) begin
         $display("FAIL direct_disable: got d=%b idx=%0d want d=%b idx=%0d", bus.d, bus.idx, ex.d, ex.idx);
      end else pass_cnt++;
   endtask

   task automatic test_scan_dwell2();
      exp_t ex;
      int   wraps = 0;
      int   errs  = 0;
      step(1'b1, 1'b0, 1'b0, 2'd0, 8'd2);
      void'(sb.pop_front());
      for (int i = 0; i < 13; i++) begin
         step(1'b1, 1'b1, 1'b0, 2'd0, 8'd2);
         ex = sb.pop_front();
         if (bus.wrap === 1'b1) wraps++;
         if ({bus.d, bus.idx, bus.wrap} !== ex) begin
            errs++;
            $display("FAIL scan_dwell2_step%0d: got d=%b idx=%0d wrap=%b want d=%b idx=%0d wrap=%b",
                     i, bus.d, bus.idx, bus.wrap, ex.d, ex.idx, ex.wrap);
         end
      end
      total++;
      if (errs == 0) pass_cnt++;
      total++;
      if (wraps != 1 || bus.idx !== 2'd0) begin
         $display("FAIL scan_dwell2_wrap: got wraps=%0d idx=%0d want wraps=1 idx=0", wraps, bus.idx);
      end else pass_cnt++;
   endtask

   task automatic test_scan_dwell0();
      exp_t ex;
      int   wraps = 0;
      int   errs  = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
         ex = sb.pop_front();
         if (bus.wrap === 1'b1) wraps++;
         if ({bus.d, bus.idx, bus.wrap} !== ex) errs++;
      end
      total++;
      if (errs != 0 || wraps != 2) begin
         $display("FAIL scan_dwell0: got errs=%0d wraps=%0d want errs=0 wraps=2", errs, wraps);
      end else pass_cnt++;
      step(1'b1, 1'b1, 1'b1, 2'd0, 8'd5);
      void'(sb.pop_front());
      repeat (3) begin
         step(1'b1, 1'b1, 1'b0, 2'd0, 8'd5);
         void'(sb.pop_front());
      end
      total++;
      if (bus.idx !== 2'd0) begin
         $display("FAIL dwell_hold: got idx=%0d want 0", bus.idx);
      end else pass_cnt++;
      step(1'b1, 1'b1, 1'b0, 2'd0, 8'd1);
      ex = sb.pop_front();
      total++;
      if ({bus.d, bus.idx, bus.wrap} !== ex || bus.idx !== 2'd1) begin
         $display("FAIL dwell_lowered: got d=%b idx=%0d want d=%b idx=1", bus.d, bus.idx, ex.d);
      end else pass_cnt++;
   endtask

   task automatic test_load();
      exp_t ex;
      step(1'b1, 1'b1, 1'b1, 2'd3, 8'd2);
      void'(sb.pop_front());
      repeat (2) begin
         step(1'b1, 1'b1, 1'b0, 2'd0, 8'd2);
         void'(sb.pop_front());
      end
      step(1'b1, 1'b1, 1'b1, 2'd2, 8'd2);
      ex = sb.pop_front();
      total++;
      if ({bus.d, bus.idx, bus.wrap} !== ex || bus.d !== 4'b0100 || bus.wrap !== 1'b0) begin
         $display("FAIL load_on_expiry: got d=%b idx=%0d wrap=%b want d=0100 idx=2 wrap=0",
                  bus.d, bus.idx, bus.wrap);
      end else pass_cnt++;
      repeat (2) begin
         step(1'b1, 1'b1, 1'b0, 2'd0, 8'd2);
         void'(sb.pop_front());
      end
      total++;
      if (bus.idx !== 2'd2) begin
         $display("FAIL load_full_dwell: got idx=%0d want 2", bus.idx);
      end else pass_cnt++;
      step(1'b1, 1'b1, 1'b0, 2'd0, 8'd2);
      ex = sb.pop_front();
      total++;
      if ({bus.d, bus.idx, bus.wrap} !== ex || bus.idx !== 2'd3) begin
         $display("FAIL load_advance: got idx=%0d want 3", bus.idx);
      end else pass_cnt++;
   endtask

   task automatic test_e_drop_and_mode();
      exp_t ex;
      int   errs = 0;
      step(1'b1, 1'b1, 1'b1, 2'd1, 8'd2);
      void'(sb.pop_front());
      step(1'b1, 1'b1, 1'b0, 2'd0, 8'd2);
      void'(sb.pop_front());
      repeat (4) begin
         step(1'b0, 1'b1, 1'b0, 2'd3, 8'd2);
         ex = sb.pop_front();
         if ({bus.d, bus.idx, bus.wrap} !== ex || bus.d !== 4'b0 || bus.idx !== 2'd1) errs++;
      end
      total++;
      if (errs != 0) begin
         $display("FAIL e_drop_idle: got %0d bad cycles want 0 (last d=%b idx=%0d)", errs, bus.d, bus.idx);
      end else pass_cnt++;
      repeat (2) begin
         step(1'b1, 1'b1, 1'b0, 2'd0, 8'd2);
         void'(sb.pop_front());
      end
      total++;
      if (bus.idx !== 2'd1 || bus.d !== 4'b0010) begin
         $display("FAIL e_resume_dwell: got d=%b idx=%0d want d=0010 idx=1", bus.d, bus.idx);
      end else pass_cnt++;
      step(1'b1, 1'b1, 1'b0, 2'd0, 8'd2);
      ex = sb.pop_front();
      total++;
      if ({bus.d, bus.idx, bus.wrap} !== ex || bus.idx !== 2'd2) begin
         $display("FAIL e_resume_advance: got idx=%0d want 2", bus.idx);
      end else pass_cnt++;
      step(1'b1, 1'b0, 1'b0, 2'd3, 8'd2);
      ex = sb.pop_front();
      total++;
      if ({bus.d, bus.idx, bus.wrap} !== ex || bus.d !== 4'b1000) begin
         $display("FAIL scan_to_direct: got d=%b idx=%0d want d=1000 idx=3", bus.d, bus.idx);
      end else pass_cnt++;
      step(1'b0, 1'b1, 1'b1, 2'd2, 8'd2);
      ex = sb.pop_front();
      total++;
      if ({bus.d, bus.idx, bus.wrap} !== ex || bus.idx !== 2'd3) begin
         $display("FAIL load_in_idle: got d=%b idx=%0d want d=0000 idx=3", bus.d, bus.idx);
      end else pass_cnt++;
      step(1'b1, 1'b0, 1'b1, 2'd0, 8'd0);
      ex = sb.pop_front();
      total++;
      if ({bus.d, bus.idx, bus.wrap} !== ex || bus.d !== 4'b0001) begin
         $display("FAIL load_in_direct: got d=%b idx=%0d want d=0001 idx=0", bus.d, bus.idx);
      end else pass_cnt++;
      // Direct->scan must start from the last decoded line with a fresh count.
      step(1'b1, 1'b1, 1'b0, 2'd3, 8'd1);
      ex = sb.pop_front();
      total++;
      if ({bus.d, bus.idx, bus.wrap} !== ex || bus.idx !== 2'd0) begin
         $display("FAIL direct_to_scan: got idx=%0d want 0", bus.idx);
      end else pass_cnt++;
   endtask

   task automatic test_n3_scan();
      exp3_t ex;
      int    errs  = 0;
      int    wraps = 0;
      logic [7:0] oh;
      bus3.e = 1'b1; bus3.mode = 1'b1; bus3.load = 1'b1; bus3.sel = 3'd0; bus3.dwell = 8'd0;
      sb3.push_back('{8'b0000_0001, 3'd0, 1'b0});
      @(posedge clk); #1;
      ex = sb3.pop_front();
      total++;
      if ({bus3.d, bus3.idx, bus3.wrap} !== ex) begin
         $display("FAIL n3_load: got d=%b idx=%0d want d=%b idx=0", bus3.d, bus3.idx, ex.d);
      end else pass_cnt++;
      bus3.load = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         oh = 8'b0;
         oh[i % 8] = 1'b1;
         sb3.push_back('{oh, 3'(i % 8), (i % 8) == 0});
         @(posedge clk); #1;
         ex = sb3.pop_front();
         if (bus3.wrap === 1'b1) wraps++;
         if ({bus3.d, bus3.idx, bus3.wrap} !== ex) begin
            errs++;
            $display("FAIL n3_step%0d: got d=%b idx=%0d wrap=%b want d=%b idx=%0d wrap=%b",
                     i, bus3.d, bus3.idx, bus3.wrap, ex.d, ex.idx, ex.wrap);
         end
      end
      total++;
      if (errs != 0 || wraps != 2) begin
         $display("FAIL n3_scan: got errs=%0d wraps=%0d want errs=0 wraps=2", errs, wraps);
      end else pass_cnt++;
      bus3.e = 1'b0;
   endtask

   task automatic test_async_reset();
      step(1'b1, 1'b1, 1'b1, 2'd3, 8'd3);
      void'(sb.pop_front());
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus.d, bus.idx, bus.wrap} !== 7'b0 || bus3.d !== 8'b0) begin
         $display("FAIL async_reset: got d=%b idx=%0d wrap=%b want 0/0/0", bus.d, bus.idx, bus.wrap);
      end else pass_cnt++;
      sb.delete();
      m_idx = 0; m_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_direct();
      test_scan_dwell2();
      test_scan_dwell0();
      test_load();
      test_e_drop_and_mode();
      test_n3_scan();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
